// File: rtl/unidade_controle_rodada_pkg.sv
// Shared types for the ultimate tic-tac-toe round controller.
// State codes are fixed numbers because the hex display and datapath decode them.
// Helper identifies the two move-waiting states where the timer runs.
package unidade_controle_rodada_pkg;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    ESPERA_MACRO  = 4'h2,
    REG_MACRO     = 4'h3,
    VALIDA_MACRO  = 4'h4,
    ESPERA_MICRO  = 4'h5,
    REG_MICRO     = 4'h6,
    VALIDA_MICRO  = 4'h7,
    ESCREVE       = 4'h8,
    CHECA_MICRO   = 4'h9,
    ESCREVE_MACRO = 4'hA,
    CHECA_FIM     = 4'hB,
    TROCA         = 4'hC,
    DESTINO       = 4'hD,
    FIM           = 4'hE
  } estado_t;

  function automatic logic eh_espera(input estado_t e);
    return (e == ESPERA_MACRO) || (e == ESPERA_MICRO);
  endfunction

endpackage

// File: rtl/unidade_controle_rodada_contador_timeout.sv
// Per-move timer: counts while enabled, saturates at TIMEOUT and flags o_fim.
// Latency: o_fim is a decode of the registered count (visible the cycle count==TIMEOUT).
// No backpressure; TIMEOUT=0 keeps o_fim low forever.
module contador_timeout #(
  parameter int TIMEOUT = 5000,
  parameter int TW      = 13
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_limpa,
  input  logic i_conta,
  output logic o_fim
);

  logic [TW-1:0] r_valor;
  logic          w_fim;

  assign w_fim = (TIMEOUT != 0) && (r_valor == TW'(TIMEOUT));
  assign o_fim = w_fim;

  // count up while enabled, hold once the limit is reached so it never wraps
  always_ff @(posedge i_clock) begin
    if (i_reset || i_limpa) begin
      r_valor <= '0;
    end else if (i_conta && !w_fim) begin
      r_valor <= r_valor + 1'b1;
    end
  end

endmodule

// File: rtl/unidade_controle_rodada.sv
// Round-sequencing Moore FSM for ultimate tic-tac-toe; drives datapath strobes and prompts.
// Latency: outputs registered alongside state; accepted press to escreve_micro is 3 cycles.
// A move is taken only on a fresh press (button seen released in the waiting state first).
module unidade_controle_rodada
  import unidade_controle_rodada_pkg::*;
#(
  parameter int TIMEOUT = 5000,
  parameter int TW      = 13
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_iniciar,
  input  logic       i_tem_jogada,
  input  logic       i_macro_valida,
  input  logic       i_destino_valido,
  input  logic       i_micro_livre,
  input  logic       i_micro_vencida,
  input  logic       i_fim_jogo,
  output logic       o_zera,
  output logic       o_registra_macro,
  output logic       o_carrega_destino,
  output logic       o_registra_micro,
  output logic       o_escreve_micro,
  output logic       o_escreve_macro,
  output logic       o_troca_jogador,
  output logic       o_jogar_macro,
  output logic       o_jogar_micro,
  output logic       o_pronto,
  output logic       o_timeout,
  output logic [3:0] o_db_estado
);

  estado_t    r_estado;
  logic       r_armado;
  logic       r_zera, r_registra_macro, r_carrega_destino, r_registra_micro;
  logic       r_escreve_micro, r_escreve_macro, r_troca_jogador;
  logic       r_jogar_macro, r_jogar_micro, r_pronto, r_timeout;
  logic [3:0] r_db_estado;

  estado_t    w_prox;
  logic       w_expirou;
  logic       w_pressao;
  logic       w_fim_tempo;

  contador_timeout #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_contador (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_limpa (!eh_espera(r_estado)),
    .i_conta (eh_espera(r_estado)),
    .o_fim   (w_fim_tempo)
  );

  assign w_pressao = i_tem_jogada && r_armado;

  // next-state decision; timer expiry takes priority over a simultaneous press
  always_comb begin
    w_prox    = r_estado;
    w_expirou = 1'b0;
    case (r_estado)
      INICIAL:       if (i_iniciar) w_prox = PREPARA;
      PREPARA:       w_prox = ESPERA_MACRO;
      ESPERA_MACRO: begin
        if (w_fim_tempo) begin
          w_prox    = FIM;
          w_expirou = 1'b1;
        end else if (w_pressao) begin
          w_prox = REG_MACRO;
        end
      end
      REG_MACRO:     w_prox = VALIDA_MACRO;
      VALIDA_MACRO:  w_prox = i_macro_valida ? ESPERA_MICRO : ESPERA_MACRO;
      ESPERA_MICRO: begin
        if (w_fim_tempo) begin
          w_prox    = FIM;
          w_expirou = 1'b1;
        end else if (w_pressao) begin
          w_prox = REG_MICRO;
        end
      end
      REG_MICRO:     w_prox = VALIDA_MICRO;
      VALIDA_MICRO:  w_prox = i_micro_livre ? ESCREVE : ESPERA_MICRO;
      ESCREVE:       w_prox = CHECA_MICRO;
      CHECA_MICRO:   w_prox = i_micro_vencida ? ESCREVE_MACRO : CHECA_FIM;
      ESCREVE_MACRO: w_prox = CHECA_FIM;
      CHECA_FIM:     w_prox = i_fim_jogo ? FIM : TROCA;
      TROCA:         w_prox = DESTINO;
      DESTINO:       w_prox = i_destino_valido ? ESPERA_MICRO : ESPERA_MACRO;
      FIM:           if (i_iniciar) w_prox = PREPARA;
      default:       w_prox = INICIAL;
    endcase
  end

  // state, release-arming flag and registered output decodes of the next state
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_estado          <= INICIAL;
      r_armado          <= 1'b0;
      r_zera            <= 1'b0;
      r_registra_macro  <= 1'b0;
      r_carrega_destino <= 1'b0;
      r_registra_micro  <= 1'b0;
      r_escreve_micro   <= 1'b0;
      r_escreve_macro   <= 1'b0;
      r_troca_jogador   <= 1'b0;
      r_jogar_macro     <= 1'b0;
      r_jogar_micro     <= 1'b0;
      r_pronto          <= 1'b0;
      r_timeout         <= 1'b0;
      r_db_estado       <= 4'h0;
    end else begin
      r_estado          <= w_prox;
      // armed once the button has been seen released while staying in a waiting state
      r_armado          <= eh_espera(w_prox) && (w_prox == r_estado) &&
                           (r_armado || !i_tem_jogada);
      r_zera            <= (w_prox == PREPARA);
      r_registra_macro  <= (w_prox == REG_MACRO);
      r_carrega_destino <= (r_estado == DESTINO) && (w_prox == ESPERA_MICRO);
      r_registra_micro  <= (w_prox == REG_MICRO);
      r_escreve_micro   <= (w_prox == ESCREVE);
      r_escreve_macro   <= (w_prox == ESCREVE_MACRO);
      r_troca_jogador   <= (w_prox == TROCA);
      r_jogar_macro     <= (w_prox == ESPERA_MACRO);
      r_jogar_micro     <= (w_prox == ESPERA_MICRO);
      r_pronto          <= (w_prox == FIM);
      r_timeout         <= (w_prox == PREPARA) ? 1'b0 : (r_timeout || w_expirou);
      r_db_estado       <= w_prox;
    end
  end

  assign o_zera            = r_zera;
  assign o_registra_macro  = r_registra_macro;
  assign o_carrega_destino = r_carrega_destino;
  assign o_registra_micro  = r_registra_micro;
  assign o_escreve_micro   = r_escreve_micro;
  assign o_escreve_macro   = r_escreve_macro;
  assign o_troca_jogador   = r_troca_jogador;
  assign o_jogar_macro     = r_jogar_macro;
  assign o_jogar_micro     = r_jogar_micro;
  assign o_pronto          = r_pronto;
  assign o_timeout         = r_timeout;
  assign o_db_estado       = r_db_estado;

endmodule
